ex_operand_stage: RTL and testbench

// ID/EX pipeline stage that sits directly upstream of the ALU and drives its operand, op and invert inputs.
// - Registers the decoded instruction from ID.
// - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
// - Selects PC/immediate operands.
// - Holds everything stable while the ALU reports insert_bubble (multi-cycle MUL/DIV/FLOAT), stalling ID meanwhile.

---
 rtl/ex_operand_stage.sv | 168 ++++++++++++++++
 tb/tb_ex_operand_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers the ID instruction, forwards from EX/MEM
// and MEM/WB, selects PC/imm operands and holds while the ALU bubbles.
// Ports: clk, rst (sync, active-high); id_* decoded instruction in;
// flush; alu_insert_bubble; exmem_*/memwb_* forwarding sources;
// left_operand/right_operand/alu_op/alu_inv_res to the ALU;
// ex_store_data, ex_rd_addr, ex_reg_write to EX/MEM;
// ex_fire, stall_id, stall_cycles.
// Optional macro EX_STALL_CNT_EN: enables the saturating stall_cycles counter.

package ex_operand_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_MULH = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REM  = 4'd14,
        ALU_REMU = 4'd15
    } alu_op_t;
endpackage

module ex_operand_stage
    import ex_operand_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [DATA_W-1:0]     id_rs1_data,
    input  logic [DATA_W-1:0]     id_rs2_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic                  id_use_pc,
    input  logic                  id_use_imm,
    input  alu_op_t               id_alu_op,
    input  logic                  id_alu_inv_res,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  flush,
    input  logic                  alu_insert_bubble,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]     exmem_data,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]     memwb_data,
    output logic [DATA_W-1:0]     left_operand,
    output logic [DATA_W-1:0]     right_operand,
    output alu_op_t               alu_op,
    output logic                  alu_inv_res,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_fire,
    output logic                  stall_id,
    output logic [31:0]           stall_cycles
);

    logic                  valid_q;
    logic                  rw_q;
    logic                  inv_q;
    logic                  use_pc_q;
    logic                  use_imm_q;
    alu_op_t               op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rs1_a_q;
    logic [REG_ADDR_W-1:0] rs2_a_q;
    logic [DATA_W-1:0]     pc_q;
    logic [DATA_W-1:0]     imm_q;
    logic [DATA_W-1:0]     rs1_d_q;
    logic [DATA_W-1:0]     rs2_d_q;
    logic [DATA_W-1:0]     rs1_res;
    logic [DATA_W-1:0]     rs2_res;

    // EX/MEM beats MEM/WB as it is the younger producer; x0 never forwards.
    always_comb begin
        rs1_res = rs1_d_q;
        rs2_res = rs2_d_q;
        if (exmem_reg_write && exmem_rd_addr == rs1_a_q && rs1_a_q != '0)
            rs1_res = exmem_data;
        else if (memwb_reg_write && memwb_rd_addr == rs1_a_q && rs1_a_q != '0)
            rs1_res = memwb_data;
        if (exmem_reg_write && exmem_rd_addr == rs2_a_q && rs2_a_q != '0)
            rs2_res = exmem_data;
        else if (memwb_reg_write && memwb_rd_addr == rs2_a_q && rs2_a_q != '0)
            rs2_res = memwb_data;
    end

    always_ff @(posedge clk) begin
        if (rst || (!alu_insert_bubble && (!id_valid || flush))) begin
            valid_q   <= 1'b0;
            rw_q      <= 1'b0;
            inv_q     <= 1'b0;
            use_pc_q  <= 1'b0;
            use_imm_q <= 1'b0;
            op_q      <= ALU_ADD;
            rd_q      <= '0;
            rs1_a_q   <= '0;
            rs2_a_q   <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_d_q   <= '0;
            rs2_d_q   <= '0;
        end else if (alu_insert_bubble) begin
            // Latch back resolved sources so a producer retiring during
            // the hold is not lost; the operands stay bit-stable.
            rs1_d_q <= rs1_res;
            rs2_d_q <= rs2_res;
            if (flush) begin
                valid_q <= 1'b0;
                rw_q    <= 1'b0;
            end
        end else begin
            valid_q   <= 1'b1;
            rw_q      <= id_reg_write;
            inv_q     <= id_alu_inv_res;
            use_pc_q  <= id_use_pc;
            use_imm_q <= id_use_imm;
            op_q      <= id_alu_op;
            rd_q      <= id_rd_addr;
            rs1_a_q   <= id_rs1_addr;
            rs2_a_q   <= id_rs2_addr;
            pc_q      <= id_pc;
            imm_q     <= id_imm;
            rs1_d_q   <= id_rs1_data;
            rs2_d_q   <= id_rs2_data;
        end
    end

    assign left_operand  = use_pc_q ? pc_q : rs1_res;
    assign right_operand = use_imm_q ? imm_q : rs2_res;
    assign ex_store_data = rs2_res;
    assign alu_op        = op_q;
    assign alu_inv_res   = inv_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_write  = rw_q;
    assign ex_fire       = valid_q & ~alu_insert_bubble;
    assign stall_id      = alu_insert_bubble;

`ifdef EX_STALL_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (alu_insert_bubble && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: instruction-level model plus
// directed scenarios (forwarding, x0, MUL hold, flush, reset, stall count).
module tb_ex_operand_stage;
    import ex_operand_pkg::*;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic        id_use_pc;
    logic        id_use_imm;
    alu_op_t     id_alu_op;
    logic        id_alu_inv_res;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        flush;
    logic        alu_insert_bubble;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd_addr;
    logic [31:0] exmem_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] memwb_data;
    logic [31:0] left_operand;
    logic [31:0] right_operand;
    alu_op_t     alu_op;
    logic        alu_inv_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_fire;
    logic        stall_id;
    logic [31:0] stall_cycles;

    ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc),
        .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
        .id_alu_op(id_alu_op), .id_alu_inv_res(id_alu_inv_res),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .flush(flush), .alu_insert_bubble(alu_insert_bubble),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
        .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
        .memwb_data(memwb_data),
        .left_operand(left_operand), .right_operand(right_operand),
        .alu_op(alu_op), .alu_inv_res(alu_inv_res),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_fire(ex_fire),
        .stall_id(stall_id), .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction currently sitting in EX, as the spec defines it.
    logic        m_valid, m_rw, m_inv, m_use_pc, m_use_imm;
    alu_op_t     m_op;
    logic [4:0]  m_rd, m_rs1a, m_rs2a;
    logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d, m_cnt;

    function automatic logic [31:0] fw(input logic [4:0] a,
                                       input logic [31:0] d);
        if (a != 0 && exmem_reg_write && exmem_rd_addr == a) return exmem_data;
        if (a != 0 && memwb_reg_write && memwb_rd_addr == a) return memwb_data;
        return d;
    endfunction

    task automatic m_clear();
        m_valid = 0; m_rw = 0; m_inv = 0; m_use_pc = 0; m_use_imm = 0;
        m_op = ALU_ADD; m_rd = 0; m_rs1a = 0; m_rs2a = 0;
        m_pc = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0;
    endtask

    always @(posedge clk) begin
        logic [31:0] r1, r2;
        r1 = fw(m_rs1a, m_rs1d);
        r2 = fw(m_rs2a, m_rs2d);
        if (rst) begin
            m_clear();
            m_cnt = 0;
        end else if (alu_insert_bubble) begin
            m_rs1d = r1;
            m_rs2d = r2;
            if (flush) begin m_valid = 0; m_rw = 0; end
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (id_valid && !flush) begin
            m_valid = 1; m_rw = id_reg_write; m_inv = id_alu_inv_res;
            m_use_pc = id_use_pc; m_use_imm = id_use_imm;
            m_op = id_alu_op; m_rd = id_rd_addr;
            m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr;
            m_pc = id_pc; m_imm = id_imm;
            m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
        end else begin
            m_clear();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_left", left_operand,
                m_use_pc ? m_pc : fw(m_rs1a, m_rs1d));
            chk("m_right", right_operand,
                m_use_imm ? m_imm : fw(m_rs2a, m_rs2d));
            chk("m_store", ex_store_data, fw(m_rs2a, m_rs2d));
            chk("m_op", 32'(alu_op), 32'(m_op));
            chk("m_inv", 32'(alu_inv_res), 32'(m_inv));
            chk("m_rd", 32'(ex_rd_addr), 32'(m_rd));
            chk("m_rw", 32'(ex_reg_write), 32'(m_rw));
            chk("m_fire", 32'(ex_fire), 32'(m_valid & ~alu_insert_bubble));
            chk("m_stall", 32'(stall_id), 32'(alu_insert_bubble));
`ifdef EX_STALL_CNT_EN
            chk("m_cnt", stall_cycles, m_cnt);
`else
            chk("m_cnt", stall_cycles, 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_id();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_use_pc = 0; id_use_imm = 0; id_alu_op = ALU_ADD;
        id_alu_inv_res = 0; id_rd_addr = 0; id_reg_write = 0;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_data = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input alu_op_t op, input logic [4:0] rd);
        idle_id();
        id_valid = 1; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_alu_op = op;
        id_rd_addr = rd; id_reg_write = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_left"}, left_operand, 32'd0);
        chk({tag, "_right"}, right_operand, 32'd0);
        chk({tag, "_store"}, ex_store_data, 32'd0);
        chk({tag, "_op"}, 32'(alu_op), 32'(ALU_ADD));
        chk({tag, "_rd"}, 32'(ex_rd_addr), 32'd0);
        chk({tag, "_rw"}, 32'(ex_reg_write), 32'd0);
        chk({tag, "_inv"}, 32'(alu_inv_res), 32'd0);
        chk({tag, "_fire"}, 32'(ex_fire), 32'd0);
        chk({tag, "_cnt"}, stall_cycles, 32'd0);
    endtask

    // One MUL with a 6-cycle bubble; optional flush in the middle.
    task automatic mul_hold(input bit do_flush);
        logic [31:0] r0;
        issue(5'd9, 5'd10, 32'h5, 32'h3, ALU_MUL, 5'd11);
        step();
        idle_id();
        issue(5'd3, 5'd4, 32'hDEAD, 32'hBEEF, ALU_SUB, 5'd12);
        memwb_reg_write = 1; memwb_rd_addr = 5'd9; memwb_data = 32'h77;
        alu_insert_bubble = 1;
        #2;
        chk("h_left0", left_operand, 32'h77);
        r0 = right_operand;
        chk("h_right0", r0, 32'h3);
        for (int i = 1; i < 6; i++) begin
            step();
            no_fwd();
            flush = do_flush && (i == 3);
            #2;
            chk("h_left", left_operand, 32'h77);
            chk("h_right", right_operand, r0);
            chk("h_op", 32'(alu_op), 32'(ALU_MUL));
            chk("h_stall", 32'(stall_id), 32'd1);
            chk("h_fire", 32'(ex_fire), 32'd0);
        end
        step();
        flush = 0;
        alu_insert_bubble = 0;
        idle_id();
        #2;
        chk("h_release_fire", 32'(ex_fire), do_flush ? 32'd0 : 32'd1);
        chk("h_release_rw", 32'(ex_reg_write), do_flush ? 32'd0 : 32'd1);
        chk("h_release_left", left_operand, 32'h77);
        step();
        chk("h_after_fire", 32'(ex_fire), 32'd0);
    endtask

    initial begin
        rst = 1; flush = 0; alu_insert_bubble = 0;
        idle_id();
        no_fwd();
        m_clear();
        m_cnt = 0;
        step();
        chk_on = 1;
        step();
        check_reset_outputs("rst");
        rst = 0;

        // 1: EX/MEM wins over MEM/WB; EX/MEM rd=x0 falls through.
        issue(5'd5, 5'd0, 32'h1111, 32'h0, ALU_ADD, 5'd7);
        step();
        idle_id();
        exmem_reg_write = 1; exmem_rd_addr = 5'd5; exmem_data = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd_addr = 5'd5; memwb_data = 32'hBBBB;
        #2;
        chk("t1_exmem", left_operand, 32'hAAAA);
        exmem_rd_addr = 5'd0;
        #1;
        chk("t1_memwb", left_operand, 32'hBBBB);
        step();
        no_fwd();

        // 2: x0 never forwarded.
        issue(5'd0, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd8);
        step();
        idle_id();
        exmem_reg_write = 1; exmem_rd_addr = 5'd0; exmem_data = 32'h1234;
        #2;
        chk("t2_x0", left_operand, 32'd0);
        step();
        no_fwd();

        // PC/imm select, inverted result, rs2 forwarded to store data.
        issue(5'd1, 5'd6, 32'h10, 32'h20, ALU_SLT, 5'd9);
        id_use_pc = 1; id_pc = 32'h100;
        id_use_imm = 1; id_imm = 32'hFFFF_FFF0; id_alu_inv_res = 1;
        step();
        idle_id();
        exmem_reg_write = 1; exmem_rd_addr = 5'd6; exmem_data = 32'hCAFE;
        #2;
        chk("t7_left", left_operand, 32'h100);
        chk("t7_right", right_operand, 32'hFFFF_FFF0);
        chk("t7_store", ex_store_data, 32'hCAFE);
        chk("t7_inv", 32'(alu_inv_res), 32'd1);
        chk("t7_fire", 32'(ex_fire), 32'd1);
        step();
        no_fwd();

        // 4: flush beats a valid instruction on advance.
        issue(5'd2, 5'd3, 32'h5, 32'h6, ALU_SUB, 5'd10);
        flush = 1;
        step();
        flush = 0;
        idle_id();
        #2;
        chk("t4_fire", 32'(ex_fire), 32'd0);
        chk("t4_rw", 32'(ex_reg_write), 32'd0);
        chk("t4_op", 32'(alu_op), 32'(ALU_ADD));
        step();

        // 5: reset in the middle of a DIV hold.
        issue(5'd4, 5'd5, 32'h64, 32'h7, ALU_DIV, 5'd13);
        step();
        idle_id();
        alu_insert_bubble = 1;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        alu_insert_bubble = 0;
        #2;
        check_reset_outputs("t5");
        step();

        // 3 and 6: two MUL holds, the second flushed mid-hold.
        mul_hold(0);
        mul_hold(1);
`ifdef EX_STALL_CNT_EN
        chk("t6_cnt", stall_cycles, 32'd12);
`else
        chk("t6_cnt", stall_cycles, 32'd0);
`endif
        step();
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
